// File: rtl/csi_frame_ctrl_pkg.sv
// Shared defaults, state encoding and lane helper for the CSI frame controller.
package csi_pkg;

  localparam int NCH_DEF     = 3;
  localparam int W_DEF       = 20;
  localparam int NSUB_DEF    = 30;
  localparam int JUMP_TH_DEF = 29;
  localparam int REF_CH_DEF  = 1;
  localparam int MODE_DEF    = 0;
  localparam int OVR_W_DEF   = 8;
  localparam int IDX_W       = $clog2(NSUB_DEF);

  typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_OUT} csi_state_e;

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_CHECK = ST_CHECK;
  localparam logic [1:0] S_OUT   = ST_OUT;

  localparam int BUS_MAX_W  = 1024;
  localparam int LANE_MAX_W = 64;

  // Lane idx of width w from a zero-extended packed bus; caller truncates to w.
  function automatic logic [LANE_MAX_W-1:0] lane_slice(input logic [BUS_MAX_W-1:0] bus,
                                                       input int unsigned idx,
                                                       input int unsigned w);
    return LANE_MAX_W'(bus >> (idx * w));
  endfunction

endpackage

// File: rtl/csi_frame_ctrl_if.sv
// Frame input / delivery bundle between CSI front end, controller and EMD consumer.
interface csi_frame_ctrl_if #(
  parameter int NCH   = 3,
  parameter int W     = 20,
  parameter int NSUB  = 30,
  parameter int OVR_W = 8
);
  localparam int IDX_W = $clog2(NSUB);

  logic                 csi_done;
  logic [NCH*W-1:0]     mag_in;
  logic [NCH*W-1:0]     pha_in;
  logic [NCH*W-1:0]     mag_out;
  logic [NCH*W-1:0]     pha_out;
  logic [IDX_W-1:0]     sub_idx;
  logic [NCH-1:0]       jump_flag;
  logic                 out_valid;
  logic                 out_ready;
  logic [OVR_W-1:0]     ovr_cnt;

  modport master (
    output csi_done, mag_in, pha_in, out_ready,
    input  mag_out, pha_out, sub_idx, jump_flag, out_valid, ovr_cnt
  );

  modport slave (
    input  csi_done, mag_in, pha_in, out_ready,
    output mag_out, pha_out, sub_idx, jump_flag, out_valid, ovr_cnt
  );
endinterface

// File: rtl/csi_frame_ctrl_jump_det.sv
// Single-channel phase-jump screen: flags prev - new above threshold at W+1 bits.
module csi_jump_det #(
  parameter int W       = 20,
  parameter int JUMP_TH = 29
) (
  input  logic [W-1:0] prev_pha_i,
  input  logic [W-1:0] new_pha_i,
  input  logic         prev_valid_i,
  output logic         jump_o
);
  localparam logic signed [W:0] TH = (W+1)'(JUMP_TH);

  logic signed [W:0] diff;

  // Sign-extend by one bit so the difference can never wrap.
  assign diff   = {prev_pha_i[W-1], prev_pha_i} - {new_pha_i[W-1], new_pha_i};
  assign jump_o = prev_valid_i && (diff > TH);
endmodule

// File: rtl/csi_frame_ctrl.sv
// Latches NCH mag/phase pairs per csi_done edge, screens phase jumps, delivers via valid/ready.
module csi_frame_ctrl
  import csi_pkg::*;
#(
  parameter int NCH     = NCH_DEF,
  parameter int W       = W_DEF,
  parameter int NSUB    = NSUB_DEF,
  parameter int JUMP_TH = JUMP_TH_DEF,
  parameter int REF_CH  = REF_CH_DEF,
  parameter int MODE    = MODE_DEF,
  parameter int OVR_W   = OVR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  csi_frame_ctrl_if.slave  bus
);
  localparam int LIDX_W = $clog2(NSUB);

  logic [1:0]        state_q, state_d;
  logic              csi_d_q;
  logic [NCH*W-1:0]  stage_mag_q, stage_mag_d, stage_pha_q, stage_pha_d;
  logic [NCH*W-1:0]  prev_pha_q, prev_pha_d;
  logic              prev_valid_q, prev_valid_d;
  logic [NCH*W-1:0]  mag_out_q, mag_out_d, pha_out_q, pha_out_d;
  logic [NCH-1:0]    jump_q, jump_d;
  logic [LIDX_W-1:0] sub_idx_q, sub_idx_d;
  logic              valid_q, valid_d;
  logic [OVR_W-1:0]  ovr_q, ovr_d;
  logic [NCH-1:0]    jump;
  logic              hit;
  logic              ev;

  assign ev = bus.csi_done && !csi_d_q && !rst;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [W-1:0] prev_lane, stage_lane;
      assign prev_lane  = W'(lane_slice(BUS_MAX_W'(prev_pha_q), gi, W));
      assign stage_lane = W'(lane_slice(BUS_MAX_W'(stage_pha_q), gi, W));
      csi_jump_det #(.W(W), .JUMP_TH(JUMP_TH)) u_det (
        .prev_pha_i   (prev_lane),
        .new_pha_i    (stage_lane),
        .prev_valid_i (prev_valid_q),
        .jump_o       (jump[gi])
      );
    end
    if (MODE != 0) begin : g_any
      assign hit = |jump;
    end else begin : g_ref
      assign hit = jump[REF_CH];
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    stage_mag_d  = stage_mag_q;
    stage_pha_d  = stage_pha_q;
    prev_pha_d   = prev_pha_q;
    prev_valid_d = prev_valid_q;
    mag_out_d    = mag_out_q;
    pha_out_d    = pha_out_q;
    jump_d       = jump_q;
    sub_idx_d    = sub_idx_q;
    valid_d      = valid_q;
    ovr_d        = ovr_q;
    case (state_q)
      S_IDLE: begin
        if (ev) begin
          stage_mag_d = bus.mag_in;
          stage_pha_d = bus.pha_in;
          state_d     = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!hit)
          sub_idx_d = (sub_idx_q == LIDX_W'(NSUB-1)) ? '0 : sub_idx_q + 1'b1;
        prev_pha_d   = stage_pha_q;
        prev_valid_d = 1'b1;
        mag_out_d    = stage_mag_q;
        pha_out_d    = stage_pha_q;
        jump_d       = jump;
        valid_d      = 1'b1;
        state_d      = S_OUT;
      end
      S_OUT: begin
        // A new frame arriving with the handshake replaces the delivered one; otherwise it is dropped.
        if (bus.out_ready) begin
          valid_d = 1'b0;
          if (ev) begin
            stage_mag_d = bus.mag_in;
            stage_pha_d = bus.pha_in;
            state_d     = S_CHECK;
          end else begin
            state_d = S_IDLE;
          end
        end else if (ev && (ovr_q != '1)) begin
          ovr_d = ovr_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      csi_d_q      <= 1'b0;
      stage_mag_q  <= '0;
      stage_pha_q  <= '0;
      prev_pha_q   <= '0;
      prev_valid_q <= 1'b0;
      mag_out_q    <= '0;
      pha_out_q    <= '0;
      jump_q       <= '0;
      sub_idx_q    <= '0;
      valid_q      <= 1'b0;
      ovr_q        <= '0;
    end else begin
      state_q      <= state_d;
      csi_d_q      <= bus.csi_done;
      stage_mag_q  <= stage_mag_d;
      stage_pha_q  <= stage_pha_d;
      prev_pha_q   <= prev_pha_d;
      prev_valid_q <= prev_valid_d;
      mag_out_q    <= mag_out_d;
      pha_out_q    <= pha_out_d;
      jump_q       <= jump_d;
      sub_idx_q    <= sub_idx_d;
      valid_q      <= valid_d;
      ovr_q        <= ovr_d;
    end
  end

  assign bus.mag_out   = mag_out_q;
  assign bus.pha_out   = pha_out_q;
  assign bus.jump_flag = jump_q;
  assign bus.sub_idx   = sub_idx_q;
  assign bus.out_valid = valid_q;
  assign bus.ovr_cnt   = ovr_q;
endmodule

// File: tb/tb_csi_frame_ctrl.sv
// Directed bench: default DUT, a MODE=1 twin and an OVR_W=2 twin driven with identical stimulus.
module tb_csi_frame_ctrl;
  localparam int NCH = 3;
  localparam int W   = 20;

  logic clk;
  logic rst;
  int   cmp_cnt;
  int   err_cnt;

  csi_frame_ctrl_if #(.NCH(NCH), .W(W), .NSUB(30), .OVR_W(8)) if_a ();
  csi_frame_ctrl_if #(.NCH(NCH), .W(W), .NSUB(30), .OVR_W(8)) if_b ();
  csi_frame_ctrl_if #(.NCH(NCH), .W(W), .NSUB(30), .OVR_W(2)) if_c ();

  csi_frame_ctrl u_dut_a (.clk(clk), .rst(rst), .bus(if_a));
  csi_frame_ctrl #(.MODE(1)) u_dut_b (.clk(clk), .rst(rst), .bus(if_b));
  csi_frame_ctrl #(.OVR_W(2)) u_dut_c (.clk(clk), .rst(rst), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  function automatic logic [NCH*W-1:0] pk(input int c0, input int c1, input int c2);
    return {W'(c2), W'(c1), W'(c0)};
  endfunction

  task automatic set_data(input logic [NCH*W-1:0] mag, input logic [NCH*W-1:0] pha);
    if_a.mag_in = mag; if_b.mag_in = mag; if_c.mag_in = mag;
    if_a.pha_in = pha; if_b.pha_in = pha; if_c.pha_in = pha;
  endtask

  task automatic set_done(input logic v);
    if_a.csi_done = v; if_b.csi_done = v; if_c.csi_done = v;
  endtask

  task automatic set_ready(input logic v);
    if_a.out_ready = v; if_b.out_ready = v; if_c.out_ready = v;
  endtask

  // Pulse csi_done for one cycle; returns at the negedge after the capturing edge.
  task automatic fire(input logic [NCH*W-1:0] mag, input logic [NCH*W-1:0] pha);
    @(negedge clk);
    set_data(mag, pha);
    set_done(1'b1);
    @(negedge clk);
    set_done(1'b0);
  endtask

  // Full frame: fire, then sample just after the edge where out_valid should rise.
  task automatic frame(input logic [NCH*W-1:0] mag, input logic [NCH*W-1:0] pha);
    fire(mag, pha);
    @(posedge clk); #1;
  endtask

  task automatic accept();
    @(negedge clk);
    set_ready(1'b1);
    @(posedge clk); #1;
    chk("accept_valid_low", 64'(if_a.out_valid), 64'd0);
    @(negedge clk);
    set_ready(1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_done(1'b0);
    set_ready(1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    cmp_cnt = 0;
    err_cnt = 0;
    rst = 1'b1;
    set_done(1'b0);
    set_ready(1'b0);
    set_data('0, '0);
    repeat (3) @(negedge clk);
    chk("rst_valid",   64'(if_a.out_valid), 64'd0);
    chk("rst_sub_idx", 64'(if_a.sub_idx),   64'd0);
    chk("rst_ovr",     64'(if_a.ovr_cnt),   64'd0);
    chk("rst_jump",    64'(if_a.jump_flag), 64'd0);
    chk("rst_mag",     64'(if_a.mag_out),   64'd0);
    chk("rst_pha",     64'(if_a.pha_out),   64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Frame 1: latency k+2, first frame never jumps.
    fire(pk(11, 22, 33), pk(5, 100, 7));
    chk("f1_valid_k1", 64'(if_a.out_valid), 64'd0);
    @(posedge clk); #1;
    chk("f1_valid_k2", 64'(if_a.out_valid), 64'd1);
    chk("f1_sub_idx",  64'(if_a.sub_idx),   64'd1);
    chk("f1_jump",     64'(if_a.jump_flag), 64'd0);
    chk("f1_mag",      64'(if_a.mag_out),   64'(pk(11, 22, 33)));
    chk("f1_pha",      64'(if_a.pha_out),   64'(pk(5, 100, 7)));
    accept();

    // Frame 2: ch1 drops by exactly the threshold -> clean.
    frame(pk(1, 1, 1), pk(5, 71, 7));
    chk("f2_jump",    64'(if_a.jump_flag), 64'd0);
    chk("f2_sub_idx", 64'(if_a.sub_idx),   64'd2);
    accept();

    // Frame 3: ch1 drops by threshold+1 -> jump, index held.
    frame(pk(1, 1, 1), pk(5, 41, 7));
    chk("f3_jump",    64'(if_a.jump_flag), 64'b010);
    chk("f3_sub_idx", 64'(if_a.sub_idx),   64'd2);
    accept();

    // Overrun: hold ready low and fire further frames.
    frame(pk(1, 2, 3), pk(5, 41, 7));
    chk("f4_sub_idx", 64'(if_a.sub_idx), 64'd3);
    repeat (3) fire(pk(9, 9, 9), pk(9, 9, 9));
    @(posedge clk); #1;
    chk("ovr3_cnt",   64'(if_a.ovr_cnt),   64'd3);
    chk("ovr3_cnt2",  64'(if_c.ovr_cnt),   64'd3);
    chk("ovr3_valid", 64'(if_a.out_valid), 64'd1);
    chk("ovr3_mag",   64'(if_a.mag_out),   64'(pk(1, 2, 3)));
    chk("ovr3_pha",   64'(if_a.pha_out),   64'(pk(5, 41, 7)));
    repeat (2) fire(pk(9, 9, 9), pk(9, 9, 9));
    @(posedge clk); #1;
    chk("ovr5_cnt",   64'(if_a.ovr_cnt), 64'd5);
    chk("ovr5_sat_w2", 64'(if_c.ovr_cnt), 64'd3);
    chk("ovr5_sub",   64'(if_a.sub_idx), 64'd3);
    accept();

    // Event coincident with handshake: both frames delivered, no drop.
    frame(pk(4, 4, 4), pk(5, 41, 7));
    chk("co_f1_mag", 64'(if_a.mag_out), 64'(pk(4, 4, 4)));
    chk("co_f1_sub", 64'(if_a.sub_idx), 64'd4);
    @(negedge clk);
    set_ready(1'b1);
    set_data(pk(6, 6, 6), pk(5, 41, 7));
    set_done(1'b1);
    @(posedge clk); #1;
    chk("co_check_valid", 64'(if_a.out_valid), 64'd0);
    @(negedge clk);
    set_ready(1'b0);
    set_done(1'b0);
    @(posedge clk); #1;
    chk("co_f2_valid", 64'(if_a.out_valid), 64'd1);
    chk("co_f2_mag",   64'(if_a.mag_out),   64'(pk(6, 6, 6)));
    chk("co_f2_sub",   64'(if_a.sub_idx),   64'd5);
    chk("co_ovr",      64'(if_a.ovr_cnt),   64'd5);

    // Asynchronous reset while a frame is pending in OUT.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(if_a.out_valid), 64'd0);
    chk("arst_sub",   64'(if_a.sub_idx),   64'd0);
    chk("arst_ovr",   64'(if_a.ovr_cnt),   64'd0);
    @(negedge clk);
    rst = 1'b0;

    // MODE comparison: ch0 drops by 50, ch1 steady.
    frame(pk(7, 7, 7), pk(100, 100, 100));
    chk("m_f1_sub_a", 64'(if_a.sub_idx), 64'd1);
    chk("m_f1_sub_b", 64'(if_b.sub_idx), 64'd1);
    accept();
    frame(pk(7, 7, 7), pk(50, 100, 100));
    chk("m1_jump",  64'(if_b.jump_flag), 64'b001);
    chk("m1_sub",   64'(if_b.sub_idx),   64'd1);
    chk("m0_jump",  64'(if_a.jump_flag), 64'b001);
    chk("m0_sub",   64'(if_a.sub_idx),   64'd2);
    accept();

    // 30 clean frames from reset with ready held high: index wraps to 0.
    do_reset();
    @(negedge clk);
    set_ready(1'b1);
    for (int i = 1; i <= 30; i++) begin
      frame(pk(i, i, i), pk(0, 0, 0));
      chk($sformatf("wrap_sub_%0d", i), 64'(if_a.sub_idx), 64'(i % 30));
    end
    @(negedge clk);
    set_ready(1'b0);
    chk("wrap_ovr", 64'(if_a.ovr_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
